// File: rtl/fifo_uart_tx.sv
// Pops bytes from a first-word-fall-through FIFO and serialises them as UART frames on tx.
// Optional even-parity bit between data and stop: define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int DAT_WIDTH = 8,
    parameter int BAUD_DIV  = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DAT_WIDTH-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 busy
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = (DAT_WIDTH > 1) ? $clog2(DAT_WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DAT_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        baud_cnt, baud_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DAT_WIDTH-1:0] shift_reg, shift_nxt;
    logic                 tx_nxt, busy_nxt, bit_end, load;

`ifdef FIFO_UART_TX_PARITY_EN
    logic parity_bit;

    // Parity is taken from the word as popped, so it does not depend on the shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     parity_bit <= 1'b0;
        else if (load) parity_bit <= ^fifo_data;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
        end
    end

    // tx and busy are registered from the next-state values so the line never glitches.
    always_comb begin
        bit_end   = (baud_cnt == BAUD_LAST);
        load      = ((state == S_IDLE) || ((state == S_STOP) && bit_end)) && enable && !fifo_empty;
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        tx_nxt    = tx;
        case (state)
            S_IDLE: begin
                baud_nxt = '0;
                tx_nxt   = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    bit_nxt   = '0;
                    tx_nxt    = shift_reg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
                        tx_nxt    = parity_bit;
`else
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                        tx_nxt  = shift_nxt[0];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_nxt = S_IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
        // A load in the last stop cycle starts the next frame with no idle gap.
        if (load) begin
            state_nxt = S_START;
            baud_nxt  = '0;
            shift_nxt = fifo_data;
            tx_nxt    = 1'b0;
        end
        busy_nxt = (state_nxt != S_IDLE);
        fifo_rd  = load;
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: directed scenarios plus random traffic against a frame-timing model.
// Build with FIFO_UART_TX_PARITY_EN defined to exercise the parity variant.
module tb_fifo_uart_tx;
    localparam int DW = 8;
    localparam int BD = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = DW + 3;
    localparam bit PAR = 1'b1;
`else
    localparam int NB = DW + 2;
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = NB * BD;

    logic          clk = 1'b0;
    logic          reset, enable, fifo_empty, fifo_rd, tx, busy;
    logic [DW-1:0] fifo_data;

    logic [7:0] mem [0:63];
    logic [5:0] head = '0;
    logic [5:0] tail = '0;

    assign fifo_empty = (head == tail);
    assign fifo_data  = mem[head];

    always #5 clk = ~clk;

    fifo_uart_tx #(.DAT_WIDTH(DW), .BAUD_DIV(BD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle counter and FIFO pop side.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!reset && fifo_rd) head <= head + 1'b1;

    // Reference model: a frame is NB bit slots of BD cycles starting the cycle after a pop.
    function automatic logic frame_bit(input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (PAR && b == DW + 1) return ^w;
        return 1'b1;
    endfunction

    int fr_start = -1000;
    int fr_end = -1;
    logic [7:0] fr_word = '0;
    logic exp_tx, exp_busy, exp_rd;
    int err_tx = 0, err_busy = 0, err_rd = 0;
    int rd_pulses = 0, busy_cyc = 0, last_rd = -1;
    logic tx_log [0:8191];

    always @(negedge clk) begin
        if (reset) begin
            fr_start = -1000;
            fr_end   = -1;
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            exp_rd   = 1'b0;
        end else begin
            exp_busy = (cyc >= fr_start) && (cyc <= fr_end);
            exp_tx   = exp_busy ? frame_bit(fr_word, (cyc - fr_start) / BD) : 1'b1;
            exp_rd   = enable && !fifo_empty && (cyc >= fr_end);
            if (exp_rd) begin
                fr_word  = fifo_data;
                fr_start = cyc + 1;
                fr_end   = cyc + FRAME;
            end
        end
        if (tx !== exp_tx) err_tx++;
        if (busy !== exp_busy) err_busy++;
        if (fifo_rd !== exp_rd) err_rd++;
        if (fifo_rd === 1'b1) begin
            rd_pulses++;
            last_rd = cyc;
        end
        if (busy === 1'b1) busy_cyc++;
        tx_log[cyc % 8192] = tx;
    end

    // Driver tasks: inputs change 1 ns after the rising edge.
    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        mem[tail] = w;
        tail = tail + 1'b1;
    endtask

    task automatic wait_rd(output int c);
        bit found = 1'b0;
        c = -1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (fifo_rd === 1'b1) begin
                found = 1'b1;
                c = cyc;
            end
        end
        if (!found) check("rd_timeout", 32'd0, 32'd1);
    endtask

    // Called right after the pop is seen; samples each bit slot one cycle into it.
    task automatic sample_frame(output logic [15:0] bits);
        bits = '0;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < BD; k++) begin
                @(negedge clk);
                if (k == 1) bits[b] = tx;
            end
    endtask

    function automatic int count_low(input int from, input int len);
        int n = 0;
        for (int i = from; i < from + len; i++) if (tx_log[i % 8192] === 1'b0) n++;
        return n;
    endfunction

    int c1, c2, s_rd, s_busy, s_tx, s_bz, s_er;
    logic [15:0] bits;

    task automatic snap();
        s_rd = rd_pulses; s_busy = busy_cyc; s_tx = err_tx; s_bz = err_busy; s_er = err_rd;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_tx_model"}, err_tx - s_tx, 0);
        check({tag, "_busy_model"}, err_busy - s_bz, 0);
        check({tag, "_rd_model"}, err_rd - s_er, 0);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle with an empty FIFO.
        snap();
        enable = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);
        check("idle_rd", rd_pulses - s_rd, 0);
        check_model("idle");

        // Single word 0xA5.
        drive_slot();
        snap();
        push(8'hA5);
        wait_rd(c1);
        sample_frame(bits);
        check("a5_bits", bits, PAR ? 32'h54A : 32'h34A);
        repeat (5) @(negedge clk);
        check("a5_rd_count", rd_pulses - s_rd, 1);
        check("a5_busy_len", busy_cyc - s_busy, FRAME);
        check_model("a5");

        // Two queued words go out back to back.
        drive_slot();
        snap();
        push(8'h00);
        push(8'hFF);
        wait_rd(c1);
        wait_rd(c2);
        check("b2b_spacing", c2 - c1, FRAME);
        repeat (FRAME + 5) @(negedge clk);
        check("b2b_low_f1", count_low(c1 + 1, FRAME), PAR ? 40 : 36);
        check("b2b_low_f2", count_low(c2 + 1, FRAME), PAR ? 8 : 4);
        check("b2b_rd_count", rd_pulses - s_rd, 2);
        check_model("b2b");

        // enable low holds words; dropping it mid-frame finishes only that frame.
        drive_slot();
        snap();
        enable = 1'b0;
        push(8'h3C);
        push(8'h5A);
        repeat (20) @(negedge clk);
        check("en_off_rd", rd_pulses - s_rd, 0);
        check("en_off_tx", tx, 1);
        drive_slot();
        enable = 1'b1;
        wait_rd(c1);
        repeat (10) @(negedge clk);
        drive_slot();
        enable = 1'b0;
        repeat (60) @(negedge clk);
        check("en_drop_rd", rd_pulses - s_rd, 1);
        check("en_drop_busy", busy, 0);
        check("en_drop_left", tail - head, 1);
        drive_slot();
        enable = 1'b1;
        wait_rd(c1);
        repeat (FRAME + 2) @(negedge clk);
        check_model("enable");

        // Reset during data bit 3 aborts the frame at once.
        drive_slot();
        snap();
        push(8'h96);
        wait_rd(c1);
        repeat (18) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_pop", rd_pulses - s_rd, 1);
        check("rst_idle_tx", tx, 1);
        check_model("reset");

        // Word 0x07 (odd number of ones).
        drive_slot();
        snap();
        push(8'h07);
        wait_rd(c1);
        sample_frame(bits);
        check("w07_bits", bits, PAR ? 32'h60E : 32'h20E);
        repeat (3) @(negedge clk);
        check("w07_busy_len", busy_cyc - s_busy, FRAME);
        check_model("w07");

        // Random traffic with random enable gaps.
        snap();
        for (int i = 0; i < 1500; i++) begin
            drive_slot();
            if ($urandom_range(0, 9) == 0 && 6'(tail - head) < 6'd60) push(8'($urandom));
            enable = ($urandom_range(0, 19) != 0);
        end
        drive_slot();
        enable = 1'b1;
        for (int i = 0; i < 5000 && head != tail; i++) @(negedge clk);
        repeat (FRAME + 5) @(negedge clk);
        check("rand_drained", tail - head, 0);
        check("rand_idle_busy", busy, 0);
        check_model("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
